// File: rtl/pulse_dispatcher.sv
// rtl/pulse_dispatcher.sv - pops pulse descriptors, waits for their start time, streams per-sample beats
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   rd_empty, rd_en, rd_*        pulse register read port (first-word-fall-through head entry)
//   counter                      shared free-running timeline counter
//   abort                        synchronous flush of the in-flight pulse
//   m_valid/m_ready              sample beat handshake towards the CORDIC/DAC path
//   m_phase/m_amp/m_env_addr     beat payload
//   m_last                       final beat of the current pulse
//   busy, late, pulse_count      status: not idle, sticky late-start flag, completed pulses

module pulse_dispatcher #(
  parameter int FREQ_W     = 32,
  parameter int PHASE_W    = 16,
  parameter int AMP_W      = 16,
  parameter int TSTART_W   = 32,
  parameter int TLEN_W     = 16,
  parameter int ENV_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_empty,
  output logic                  rd_en,
  input  logic [FREQ_W-1:0]     rd_freq,
  input  logic [PHASE_W-1:0]    rd_phase,
  input  logic [AMP_W-1:0]      rd_amp,
  input  logic [TSTART_W-1:0]   rd_tstart,
  input  logic [TLEN_W-1:0]     rd_tlen,
  input  logic [ENV_ADDR_W-1:0] rd_env_addr,
  input  logic [TSTART_W-1:0]   counter,
  input  logic                  abort,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PHASE_W-1:0]    m_phase,
  output logic [AMP_W-1:0]      m_amp,
  output logic [ENV_ADDR_W-1:0] m_env_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  late,
  output logic [15:0]           pulse_count
);

  typedef enum logic [1:0] {IDLE, WAIT, PLAY} state_t;

  state_t                state_q, state_d;
  logic [FREQ_W-1:0]     freq_q, freq_d;
  logic [FREQ_W-1:0]     acc_q, acc_d;
  logic [AMP_W-1:0]      amp_q, amp_d;
  logic [TSTART_W-1:0]   tstart_q, tstart_d;
  logic [TLEN_W-1:0]     tlen_q, tlen_d;
  logic [TLEN_W-1:0]     n_q, n_d;
  logic [ENV_ADDR_W-1:0] env_q, env_d;
  logic                  late_q, late_d;
  logic [15:0]           pulse_count_q, pulse_count_d;

  logic [TSTART_W-1:0]   diff;
  logic                  pop;
  logic                  last_beat;
  logic                  handshake;

  // Modular distance to the start time: MSB set means the start time is already behind us.
  assign diff      = tstart_q - counter;
  assign last_beat = (state_q == PLAY) && (n_q == tlen_q - 1'b1);
  assign handshake = (state_q == PLAY) && m_ready;
  // abort outranks the pop; rst gating keeps the strobe quiet while the flops are held in reset.
  assign pop       = (state_q == IDLE) && !rd_empty && !abort;
  assign rd_en     = pop && !rst;

  assign m_valid     = (state_q == PLAY);
  assign m_last      = last_beat;
  assign m_phase     = acc_q[FREQ_W-1 -: PHASE_W];
  assign m_amp       = amp_q;
  assign m_env_addr  = env_q;
  assign busy        = (state_q != IDLE);
  assign late        = late_q;
  assign pulse_count = pulse_count_q;

  always_comb begin
    state_d       = state_q;
    freq_d        = freq_q;
    acc_d         = acc_q;
    amp_d         = amp_q;
    tstart_d      = tstart_q;
    tlen_d        = tlen_q;
    n_d           = n_q;
    env_d         = env_q;
    late_d        = late_q;
    pulse_count_d = pulse_count_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          // The phase accumulator and envelope pointer are primed at pop time and
          // simply held through WAIT, so PLAY entry needs no extra load cycle.
          freq_d   = rd_freq;
          acc_d    = FREQ_W'(rd_phase) << (FREQ_W - PHASE_W);
          amp_d    = rd_amp;
          tstart_d = rd_tstart;
          tlen_d   = rd_tlen;
          n_d      = '0;
          env_d    = rd_env_addr;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tlen_q == '0) begin
          state_d = IDLE;
        end else if (diff == '0) begin
          state_d = PLAY;
        end else if (diff[TSTART_W-1]) begin
          late_d  = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (handshake) begin
          acc_d = acc_q + freq_q;
          env_d = env_q + 1'b1;
          n_d   = n_q + 1'b1;
          if (last_beat) begin
            state_d       = IDLE;
            pulse_count_d = pulse_count_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d       = IDLE;
      late_d        = 1'b0;
      pulse_count_d = pulse_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      freq_q        <= '0;
      acc_q         <= '0;
      amp_q         <= '0;
      tstart_q      <= '0;
      tlen_q        <= '0;
      n_q           <= '0;
      env_q         <= '0;
      late_q        <= 1'b0;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      freq_q        <= freq_d;
      acc_q         <= acc_d;
      amp_q         <= amp_d;
      tstart_q      <= tstart_d;
      tlen_q        <= tlen_d;
      n_q           <= n_d;
      env_q         <= env_d;
      late_q        <= late_d;
      pulse_count_q <= pulse_count_d;
    end
  end

endmodule

// File: tb/tb_pulse_dispatcher.sv
// tb/tb_pulse_dispatcher.sv - self-checking bench for pulse_dispatcher

module tb_pulse_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_empty;
  logic        rd_en;
  logic [31:0] rd_freq;
  logic [15:0] rd_phase;
  logic [15:0] rd_amp;
  logic [31:0] rd_tstart;
  logic [15:0] rd_tlen;
  logic [9:0]  rd_env_addr;
  logic [31:0] counter = 32'd0;
  logic        abort;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_phase;
  logic [15:0] m_amp;
  logic [9:0]  m_env_addr;
  logic        m_last;
  logic        busy;
  logic        late;
  logic [15:0] pulse_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Timeline counter with a one-shot load for jumping to interesting values.
  logic        ld = 1'b0;
  logic [31:0] ld_val = 32'd0;
  always @(posedge clk) counter <= ld ? ld_val : counter + 32'd1;

  // Pulse register model: 16-entry FWFT FIFO.
  logic [31:0] f_mem  [16];
  logic [15:0] ph_mem [16];
  logic [15:0] a_mem  [16];
  logic [31:0] ts_mem [16];
  logic [15:0] tl_mem [16];
  logic [9:0]  e_mem  [16];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;

  assign rd_empty    = (wr_ptr == rd_ptr);
  assign rd_freq     = f_mem[rd_ptr];
  assign rd_phase    = ph_mem[rd_ptr];
  assign rd_amp      = a_mem[rd_ptr];
  assign rd_tstart   = ts_mem[rd_ptr];
  assign rd_tlen     = tl_mem[rd_ptr];
  assign rd_env_addr = e_mem[rd_ptr];

  always @(posedge clk) if (rd_en) rd_ptr <= rd_ptr + 4'd1;

  pulse_dispatcher dut (
    .clk(clk), .rst(rst), .rd_empty(rd_empty), .rd_en(rd_en),
    .rd_freq(rd_freq), .rd_phase(rd_phase), .rd_amp(rd_amp),
    .rd_tstart(rd_tstart), .rd_tlen(rd_tlen), .rd_env_addr(rd_env_addr),
    .counter(counter), .abort(abort),
    .m_valid(m_valid), .m_ready(m_ready), .m_phase(m_phase), .m_amp(m_amp),
    .m_env_addr(m_env_addr), .m_last(m_last),
    .busy(busy), .late(late), .pulse_count(pulse_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // rd_en must never fire into an empty register or while reset is held.
  always @(negedge clk) begin
    #1;
    chk("rd_en_guard", 64'(rd_en && (rd_empty || rst)), 64'd0);
  end

  task automatic push(input logic [31:0] f, input logic [15:0] ph, input logic [15:0] amp,
                      input logic [31:0] ts, input logic [15:0] tl, input logic [9:0] env);
    f_mem[wr_ptr]  = f;
    ph_mem[wr_ptr] = ph;
    a_mem[wr_ptr]  = amp;
    ts_mem[wr_ptr] = ts;
    tl_mem[wr_ptr] = tl;
    e_mem[wr_ptr]  = env;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    abort   = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = rd_ptr;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_cnt(input logic [31:0] v);
    ld     = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] c);
    int n = 0;
    while (counter !== c && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cnt", 64'(counter), 64'(c));
  endtask

  // Streams one pulse with m_ready held high; ends one cycle after the m_last handshake.
  task automatic play_collect(input int max_cyc, output int beats, output logic [31:0] first_cnt,
                              output logic [15:0] last_phase, output logic [9:0] last_env);
    bit done = 0;
    beats      = 0;
    first_cnt  = '1;
    last_phase = '0;
    last_env   = '0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        if (beats == 0) first_cnt = counter;
        beats++;
        last_phase = m_phase;
        last_env   = m_env_addr;
        if (m_last) done = 1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int          seq;
    logic [31:0] cnt;
    bit          ready;
    bit          exp_valid;
    logic [15:0] exp_phase;
    logic [9:0]  exp_env;
    bit          exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int s, input logic [31:0] c, input bit r, input bit v,
                         input logic [15:0] ph, input logic [9:0] e, input bit l);
    vec_t x;
    x.seq = s; x.cnt = c; x.ready = r; x.exp_valid = v;
    x.exp_phase = ph; x.exp_env = e; x.exp_last = l;
    vecs.push_back(x);
  endtask

  initial begin
    int          beats;
    int          hs;
    int          bv;
    logic [31:0] first;
    logic [15:0] lph;
    logic [9:0]  lenv;

    // seq 0: m_ready held high; seq 1: stalls at 102,103,106.
    add_vec(0, 100, 1, 0, 16'h0000, 10'd0, 0);
    add_vec(0, 101, 1, 1, 16'h1000, 10'd5, 0);
    add_vec(0, 102, 1, 1, 16'h1100, 10'd6, 0);
    add_vec(0, 103, 1, 1, 16'h1200, 10'd7, 0);
    add_vec(0, 104, 1, 1, 16'h1300, 10'd8, 1);
    add_vec(0, 105, 1, 0, 16'h0000, 10'd0, 0);
    add_vec(1, 100, 1, 0, 16'h0000, 10'd0, 0);
    add_vec(1, 101, 1, 1, 16'h1000, 10'd5, 0);
    add_vec(1, 102, 0, 1, 16'h1100, 10'd6, 0);
    add_vec(1, 103, 0, 1, 16'h1100, 10'd6, 0);
    add_vec(1, 104, 1, 1, 16'h1100, 10'd6, 0);
    add_vec(1, 105, 1, 1, 16'h1200, 10'd7, 0);
    add_vec(1, 106, 0, 1, 16'h1300, 10'd8, 1);
    add_vec(1, 107, 1, 1, 16'h1300, 10'd8, 1);
    add_vec(1, 108, 1, 0, 16'h0000, 10'd0, 0);

    rst = 1'b1; abort = 1'b0; m_ready = 1'b0;
    do_reset();
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_late", 64'(late), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_pulse_count", 64'(pulse_count), 64'd0);
    chk("rst_m_phase", 64'(m_phase), 64'd0);
    chk("rst_m_amp", 64'(m_amp), 64'd0);
    chk("rst_m_env_addr", 64'(m_env_addr), 64'd0);

    // Single pulse and backpressure, table driven.
    for (int s = 0; s < 2; s++) begin
      do_reset();
      load_cnt(32'd90);
      push(32'h0100_0000, 16'h1000, 16'h7FFF, 32'd100, 16'd4, 10'd5);
      m_ready = 1'b1;
      hs = 0;
      foreach (vecs[i]) begin
        if (vecs[i].seq == s) begin
          wait_cnt(vecs[i].cnt);
          m_ready = vecs[i].ready;
          #1;
          chk($sformatf("s%0d_c%0d_valid", s, vecs[i].cnt), 64'(m_valid), 64'(vecs[i].exp_valid));
          if (m_valid && m_ready) hs++;
          if (vecs[i].exp_valid) begin
            chk($sformatf("s%0d_c%0d_phase", s, vecs[i].cnt), 64'(m_phase), 64'(vecs[i].exp_phase));
            chk($sformatf("s%0d_c%0d_env", s, vecs[i].cnt), 64'(m_env_addr), 64'(vecs[i].exp_env));
            chk($sformatf("s%0d_c%0d_last", s, vecs[i].cnt), 64'(m_last), 64'(vecs[i].exp_last));
            chk($sformatf("s%0d_c%0d_amp", s, vecs[i].cnt), 64'(m_amp), 64'h7FFF);
          end
        end
      end
      chk($sformatf("s%0d_handshakes", s), 64'(hs), 64'd4);
      chk($sformatf("s%0d_pulse_count", s), 64'(pulse_count), 64'd1);
      chk($sformatf("s%0d_late", s), 64'(late), 64'd0);
      chk($sformatf("s%0d_busy", s), 64'(busy), 64'd0);
    end

    // Late start: t_start already behind the counter.
    do_reset();
    load_cnt(32'd50);
    push(32'h0100_0000, 16'h0000, 16'h0100, 32'd10, 16'd2, 10'd0);
    play_collect(40, beats, first, lph, lenv);
    chk("late_first_cnt", 64'(first), 64'd52);
    chk("late_beats", 64'(beats), 64'd2);
    chk("late_flag", 64'(late), 64'd1);
    chk("late_pulse_count", 64'(pulse_count), 64'd1);

    // Counter wrap: t_start=2 seen from 0xFFFF_FFFE is in the future.
    do_reset();
    load_cnt(32'hFFFF_FFFE);
    push(32'h0100_0000, 16'h0000, 16'h0100, 32'd2, 16'd1, 10'd0);
    play_collect(40, beats, first, lph, lenv);
    chk("wrap_first_cnt", 64'(first), 64'd3);
    chk("wrap_beats", 64'(beats), 64'd1);
    chk("wrap_late", 64'(late), 64'd0);
    chk("wrap_pulse_count", 64'(pulse_count), 64'd1);

    // tlen=0 discarded, then a 2-beat pulse whose envelope address wraps.
    do_reset();
    load_cnt(32'd1000);
    push(32'h0100_0000, 16'h1111, 16'h0100, 32'd1005, 16'd0, 10'd7);
    push(32'h0200_0000, 16'h0800, 16'h0100, 32'd1020, 16'd2, 10'h3FF);
    play_collect(60, beats, first, lph, lenv);
    chk("tlen0_first_cnt", 64'(first), 64'd1021);
    chk("tlen0_beats", 64'(beats), 64'd2);
    chk("tlen0_last_phase", 64'(lph), 64'h0A00);
    chk("tlen0_env_wrap", 64'(lenv), 64'd0);
    chk("tlen0_pulse_count", 64'(pulse_count), 64'd1);

    // Reset mid-PLAY: A completes (count=1, late=1), B reset during its 3rd beat.
    do_reset();
    load_cnt(32'd200);
    push(32'h0010_0000, 16'h0000, 16'h0100, 32'd10, 16'd2, 10'd0);
    push(32'h0010_0000, 16'h2000, 16'h0200, 32'd20, 16'd8, 10'd0);
    push(32'h0010_0000, 16'h3000, 16'h0300, 32'h1000, 16'd1, 10'd0);
    play_collect(40, beats, first, lph, lenv);
    chk("rstmid_a_beats", 64'(beats), 64'd2);
    chk("rstmid_pre_count", 64'(pulse_count), 64'd1);
    chk("rstmid_pre_late", 64'(late), 64'd1);
    bv = 0;
    for (int i = 0; i < 40 && bv < 3; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        bv++;
        if (bv == 3) rst = 1'b1;
      end
    end
    chk("rstmid_reached_beat3", 64'(bv), 64'd3);
    #1;
    chk("rstmid_rd_en_in_rst", 64'(rd_en), 64'd0);
    @(negedge clk);
    #1;
    chk("rstmid_m_valid", 64'(m_valid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_late", 64'(late), 64'd0);
    chk("rstmid_pulse_count", 64'(pulse_count), 64'd0);
    chk("rstmid_rd_en", 64'(rd_en), 64'd0);
    rst = 1'b0;

    // Abort on beat 2 of 5 with a coincident m_ready; next pulse plays normally.
    do_reset();
    load_cnt(32'd2000);
    push(32'h0010_0000, 16'h4000, 16'h0100, 32'd1990, 16'd5, 10'd0);
    push(32'h0010_0000, 16'h5000, 16'h0100, 32'd2040, 16'd3, 10'd0);
    bv = 0;
    for (int i = 0; i < 40 && bv < 2; i++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (m_valid) begin
        bv++;
        if (bv == 2) begin
          chk("abort_pre_late", 64'(late), 64'd1);
          chk("abort_beat2_phase", 64'(m_phase), 64'h4010);
          abort = 1'b1;
        end
      end
    end
    chk("abort_reached_beat2", 64'(bv), 64'd2);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_late", 64'(late), 64'd0);
    chk("abort_pulse_count", 64'(pulse_count), 64'd0);
    chk("abort_next_pop", 64'(rd_en), 64'd1);
    play_collect(80, beats, first, lph, lenv);
    chk("abort_next_first_cnt", 64'(first), 64'd2041);
    chk("abort_next_beats", 64'(beats), 64'd3);
    chk("abort_next_last_phase", 64'(lph), 64'h5020);
    chk("abort_next_pulse_count", 64'(pulse_count), 64'd1);
    chk("abort_next_late", 64'(late), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_dispatcher.md
# pulse_dispatcher

Reader side of the pulse register FIFO: pops queued pulse descriptors, holds each until the free-running timeline counter reaches its start time, then streams it as per-sample beats (phase, amplitude, envelope address) to the CORDIC/DAC stream path. It sits between the pulse register and the DAC stream module, driving the register's read port and consuming the shared timeline counter.

## Interface
- FREQ_W, 32, frequency word width (phase increment per sample); FREQ_W >= PHASE_W
- PHASE_W, 16, phase width
- AMP_W, 16, amplitude width
- TSTART_W, 32, start-time width; equals counter width
- TLEN_W, 16, pulse length in samples
- ENV_ADDR_W, 10, envelope memory address width
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- rd_empty  in  1  pulse register empty
- rd_en  out  1  pop strobe, one cycle per pulse
- rd_freq / rd_phase / rd_amp / rd_tstart / rd_tlen / rd_env_addr  in  FREQ_W / PHASE_W / AMP_W / TSTART_W / TLEN_W / ENV_ADDR_W  head entry (first-word-fall-through, valid while !rd_empty)
- counter  in  TSTART_W  timeline counter, +1 per clk, wraps
- abort  in  1  synchronous flush of the in-flight pulse
- m_valid  out  1  sample beat valid
- m_ready  in  1  downstream accept
- m_phase  out  PHASE_W  instantaneous phase
- m_amp  out  AMP_W  amplitude
- m_env_addr  out  ENV_ADDR_W  envelope sample address
- m_last  out  1  final beat of pulse
- busy  out  1  state != IDLE
- late  out  1  sticky: a pulse started after its t_start
- pulse_count  out  16  completed pulses, wraps mod 2^16

## Operation
- States: IDLE, WAIT, PLAY.
- IDLE: if !rd_empty, latch head fields into working registers, assert rd_en this cycle, go WAIT. Else stay.
- WAIT: diff = rd_tstart_latched - counter (TSTART_W-bit, modulo). diff == 0 -> PLAY. diff MSB set (start time already past) -> set late, go PLAY. Otherwise stay. If tlen == 0 -> discard, return IDLE, pulse_count unchanged, no beats.
- PLAY entry: acc = {phase, (FREQ_W-PHASE_W)'b0}, n = 0, env = env_addr.
- PLAY beat outputs: m_phase = acc[FREQ_W-1 -: PHASE_W], m_amp = amp, m_env_addr = env, m_last = (n == tlen-1).
- On handshake (m_valid && m_ready): acc += freq (mod 2^FREQ_W), env += 1 (mod 2^ENV_ADDR_W), n += 1. Handshake with m_last -> IDLE, pulse_count += 1.
- abort (any state): next state IDLE, m_valid deasserts next cycle, working pulse dropped, late cleared, pulse_count unchanged. Already-popped entry is not restored. abort outranks every other transition, including a coincident last handshake (that pulse is not counted).
- Reset: state IDLE; rd_en, m_valid, m_last, busy, late = 0; m_phase, m_amp, m_env_addr, pulse_count = 0.

## Timing
- rd_en is asserted combinationally in IDLE when !rd_empty, at most one cycle per pulse; never asserted when rd_empty = 1.
- IDLE->WAIT: 1 cycle. WAIT sees counter == t_start on edge k -> m_valid high from cycle k+1 (fixed 1-cycle launch latency, compensated downstream).
- With m_ready held high: exactly tlen consecutive beats, m_last on beat tlen-1.
- AXI rule: once m_valid is high, payload is held stable and m_valid stays high until handshake; abort and rst are the only exceptions.
- Back-to-back pulses: minimum 2 idle cycles between last beat of one pulse and first of the next (IDLE, WAIT); a next pulse whose t_start falls inside that gap starts late with late = 1.
- Counter wrap: diff comparison is modular; t_start within 2^(TSTART_W-1) ahead of counter is treated as future.
- busy rises the cycle after the pop and falls the cycle after the final handshake or abort.

## Test plan
- Reset mid-PLAY (rst pulse during beat 3 of 8) -> m_valid, busy, late, pulse_count all 0 next cycle; no rd_en while rst high.
- Single pulse: phase=0x1000, freq=0x0100_0000, amp=0x7FFF, env_addr=5, tstart=100, tlen=4, m_ready=1 -> m_valid cycles with counter 101..104; m_phase 0x1000,0x1100,0x1200,0x1300; m_env_addr 5..8; m_last on 4th beat; pulse_count=1; late=0.
- Backpressure: same pulse, m_ready toggled 1,0,0,1,… -> payload stable while stalled; exactly 4 handshakes; phases unchanged sequence.
- Late start and wrap: tstart=10 queued at counter=50 -> starts immediately, late=1; tstart=0x0000_0002 queued at counter=0xFFFF_FFFE -> waits, starts after counter=2, late not set by it.
- tlen=0 followed by tlen=2 pulse -> first popped and discarded with no beats, second streams 2 beats, pulse_count=1.
- abort during beat 2 of 5 with a coincident m_ready -> m_valid low next cycle, pulse_count unchanged, late=0; next queued pulse pops and plays normally.
